// File: rtl/uart_tx_slave.sv
// uart_tx_slave: memory-mapped 8N1 UART transmitter with a small TX FIFO,
// programmable bit period and a registered read-data port.
module uart_tx_slave #(
    parameter int BUS_WIDTH     = 32,
    parameter int FIFO_DEPTH    = 4,
    parameter int RESET_BAUDDIV = 867
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst_n,
    input  logic                 i_WEnable,
    input  logic [BUS_WIDTH-1:0] i_WAddr,
    input  logic [BUS_WIDTH-1:0] i_WData,
    input  logic                 i_REnable,
    input  logic [BUS_WIDTH-1:0] i_RAddr,
    output logic [BUS_WIDTH-1:0] o_RData,
    output logic                 o_Tx,
    output logic                 o_Irq
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [7:0]      fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   count;

    logic [15:0]     bauddiv;
    logic            txen;
    logic            irqen;
    logic            ovf;

    logic [7:0]      shift;
    logic [15:0]     divisor;
    logic [15:0]     baud_cnt;
    logic [2:0]      bit_cnt;

    logic            wr_en;
    logic            rd_en;
    logic            fifo_full;
    logic            fifo_empty;
    logic            busy;
    logic            bit_end;
    logic            pop;
    logic            push_req;
    logic            push_ok;
    logic [BUS_WIDTH-1:0] rd_mux;
    logic            unused_bits;

    // Strobes only count when driven to a clean 1, so a floating bus reads as idle.
    assign wr_en      = (i_WEnable === 1'b1);
    assign rd_en      = (i_REnable === 1'b1);
    assign fifo_full  = (count == CW'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign busy       = (state != IDLE);
    assign bit_end    = (baud_cnt == divisor);
    // A frame starts either from idle or directly at the end of a stop bit.
    assign pop        = txen && !fifo_empty &&
                        ((state == IDLE) || ((state == STOP) && bit_end));
    assign push_req   = wr_en && (i_WAddr[1:0] == 2'd0);
    assign push_ok    = push_req && (!fifo_full || pop);
    assign o_Irq      = irqen && fifo_empty && !busy;
    assign unused_bits = ^{i_WAddr[BUS_WIDTH-1:2], i_RAddr[BUS_WIDTH-1:2],
                           i_WData[BUS_WIDTH-1:16]};

    // State register for the serialiser.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: each non-idle state advances only at the end of a bit period.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:  if (pop) state_next = START;
            START: if (bit_end) state_next = DATA;
            DATA:  if (bit_end && (bit_cnt == 3'd7)) state_next = STOP;
            STOP:  if (bit_end) state_next = pop ? START : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Line driver: low start bit, LSB-first data, high stop bit and idle.
    always_comb begin
        o_Tx = 1'b1;
        unique case (state)
            START:   o_Tx = 1'b0;
            DATA:    o_Tx = shift[0];
            default: o_Tx = 1'b1;
        endcase
    end

    // Bit timing and shifting; the divisor is latched per frame so BAUDDIV writes wait.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            shift    <= '0;
            divisor  <= '0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
        end else if (pop) begin
            shift    <= fifo_mem[rd_ptr];
            divisor  <= bauddiv;
            baud_cnt <= '0;
            bit_cnt  <= '0;
        end else if (state != IDLE) begin
            if (bit_end) begin
                baud_cnt <= '0;
                if (state == DATA) begin
                    shift   <= shift >> 1;
                    bit_cnt <= bit_cnt + 3'd1;
                end
            end else begin
                baud_cnt <= baud_cnt + 16'd1;
            end
        end
    end

    // FIFO storage has no reset; only the pointers and count define its contents.
    always_ff @(posedge i_Clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= i_WData[7:0];
        end
    end

    // FIFO pointers and occupancy; a push and pop on one edge leaves the count unchanged.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            unique case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Control registers; a dropped push sets OVF and that takes priority over a clear.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            bauddiv <= 16'(RESET_BAUDDIV);
            txen    <= 1'b0;
            irqen   <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            if (wr_en && (i_WAddr[1:0] == 2'd2)) bauddiv <= i_WData[15:0];
            if (wr_en && (i_WAddr[1:0] == 2'd3)) begin
                txen  <= i_WData[0];
                irqen <= i_WData[1];
            end
            if (push_req && !push_ok) begin
                ovf <= 1'b1;
            end else if (wr_en && (i_WAddr[1:0] == 2'd1) && i_WData[6]) begin
                ovf <= 1'b0;
            end
        end
    end

    // Read-data mux built from pre-edge register values.
    always_comb begin
        rd_mux = '0;
        unique case (i_RAddr[1:0])
            2'd1: begin
                rd_mux[0]   = fifo_full;
                rd_mux[1]   = fifo_empty;
                rd_mux[2]   = busy;
                rd_mux[5:3] = 3'(count);
                rd_mux[6]   = ovf;
            end
            2'd2:    rd_mux[15:0] = bauddiv;
            2'd3:    rd_mux[1:0]  = {irqen, txen};
            default: rd_mux = '0;
        endcase
    end

    // Registered read port; holds its value when no read is requested.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            o_RData <= '0;
        end else if (rd_en) begin
            o_RData <= rd_mux;
        end
    end

endmodule

// File: tb/tb_uart_tx_slave.sv
// tb_uart_tx_slave: directed self-checking bench for the UART TX slave.
module tb_uart_tx_slave;

    logic        i_Clk = 1'b0;
    logic        i_Rst_n = 1'b0;
    logic        i_WEnable = 1'b0;
    logic [31:0] i_WAddr = '0;
    logic [31:0] i_WData = '0;
    logic        i_REnable = 1'b0;
    logic [31:0] i_RAddr = '0;
    logic [31:0] o_RData;
    logic        o_Tx;
    logic        o_Irq;

    int tests_run = 0;
    int tests_failed = 0;

    uart_tx_slave #(
        .BUS_WIDTH(32),
        .FIFO_DEPTH(4),
        .RESET_BAUDDIV(867)
    ) dut (
        .i_Clk(i_Clk),
        .i_Rst_n(i_Rst_n),
        .i_WEnable(i_WEnable),
        .i_WAddr(i_WAddr),
        .i_WData(i_WData),
        .i_REnable(i_REnable),
        .i_RAddr(i_RAddr),
        .o_RData(o_RData),
        .o_Tx(o_Tx),
        .o_Irq(o_Irq)
    );

    // 100 MHz clock.
    always #5 i_Clk = ~i_Clk;

    // Single point of comparison: counts the check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Register write landing on the next rising edge; returns 1 ns after that edge.
    task automatic writeReg(input logic [1:0] idx, input logic [31:0] data);
        @(negedge i_Clk);
        i_WEnable = 1'b1;
        i_WAddr   = {30'd0, idx};
        i_WData   = data;
        @(posedge i_Clk);
        #1;
        i_WEnable = 1'b0;
    endtask

    // Register read; the registered data is sampled 1 ns after the request edge.
    task automatic readReg(input logic [1:0] idx, output logic [31:0] data);
        @(negedge i_Clk);
        i_REnable = 1'b1;
        i_RAddr   = {30'd0, idx};
        @(posedge i_Clk);
        #1;
        i_REnable = 1'b0;
        data = o_RData;
    endtask

    // Checks one full frame cycle by cycle; call 1 ns after the edge that begins the start bit.
    task automatic expectFrame(input logic [7:0] data_byte, input int div);
        logic [9:0] bits;
        bits = {1'b1, data_byte, 1'b0};
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c <= div; c++) begin
                checkOutput($sformatf("tx_bit%0d", b), {31'd0, o_Tx}, {31'd0, bits[b]});
                @(posedge i_Clk);
                #1;
            end
        end
    endtask

    // Guards against a hung run.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence.
    initial begin
        logic [31:0] rd;

        // Reset state
        #1;
        checkOutput("rst_tx", {31'd0, o_Tx}, 32'd1);
        checkOutput("rst_rdata", o_RData, 32'd0);
        checkOutput("rst_irq", {31'd0, o_Irq}, 32'd0);
        @(negedge i_Clk);
        @(negedge i_Clk);
        i_Rst_n = 1'b1;
        readReg(2'd1, rd); checkOutput("rst_status", rd, 32'h0000_0002);
        readReg(2'd2, rd); checkOutput("rst_bauddiv", rd, 32'd867);
        readReg(2'd3, rd); checkOutput("rst_ctrl", rd, 32'd0);
        readReg(2'd0, rd); checkOutput("txdata_read", rd, 32'd0);

        // Single byte at a 4-clock bit period
        writeReg(2'd2, 32'hFFFF_0003);
        readReg(2'd2, rd); checkOutput("bauddiv_rw", rd, 32'd3);
        writeReg(2'd3, 32'd1);
        writeReg(2'd0, 32'h0000_00A5);
        checkOutput("pre_start_idle", {31'd0, o_Tx}, 32'd1);
        @(posedge i_Clk);
        #1;
        fork
            expectFrame(8'hA5, 3);
            begin
                repeat (5) @(posedge i_Clk);
                readReg(2'd1, rd);
                checkOutput("busy_mid_frame", rd & 32'h4, 32'h4);
            end
        join
        readReg(2'd1, rd); checkOutput("status_after_frame", rd, 32'h0000_0002);

        // Overflow with the transmitter disabled, then drain back-to-back
        writeReg(2'd3, 32'd0);
        for (int i = 1; i <= 5; i++) writeReg(2'd0, i);
        readReg(2'd1, rd); checkOutput("ovf_status", rd, 32'h0000_0061);
        writeReg(2'd1, 32'h0000_0040);
        readReg(2'd1, rd); checkOutput("ovf_cleared", rd, 32'h0000_0021);
        writeReg(2'd3, 32'd1);
        @(posedge i_Clk);
        #1;
        for (int i = 1; i <= 4; i++) expectFrame(8'(i), 3);
        for (int i = 0; i < 12; i++) begin
            checkOutput("idle_after_drain", {31'd0, o_Tx}, 32'd1);
            @(posedge i_Clk);
            #1;
        end
        readReg(2'd1, rd); checkOutput("drained_status", rd, 32'h0000_0002);

        // Interrupt around a single frame
        writeReg(2'd3, 32'd3);
        checkOutput("irq_idle_empty", {31'd0, o_Irq}, 32'd1);
        writeReg(2'd0, 32'h0000_003C);
        checkOutput("irq_after_push", {31'd0, o_Irq}, 32'd0);
        @(posedge i_Clk);
        #1;
        fork
            expectFrame(8'h3C, 3);
            begin
                repeat (20) @(posedge i_Clk);
                #1;
                checkOutput("irq_busy", {31'd0, o_Irq}, 32'd0);
            end
        join
        checkOutput("irq_after_stop", {31'd0, o_Irq}, 32'd1);
        readReg(2'd1, rd); checkOutput("irq_status", rd, 32'h0000_0002);

        // Push on the same edge as a back-to-back pop while full
        writeReg(2'd0, 32'h11);
        for (int i = 2; i <= 5; i++) writeReg(2'd0, 32'h10 + i);
        repeat (36) @(posedge i_Clk);
        writeReg(2'd0, 32'h16);
        readReg(2'd1, rd); checkOutput("push_on_pop_status", rd, 32'h0000_0025);

        // Clearing TXEN mid-frame finishes only the current frame
        writeReg(2'd3, 32'd2);
        repeat (60) @(posedge i_Clk);
        #1;
        checkOutput("disabled_idle_tx", {31'd0, o_Tx}, 32'd1);
        readReg(2'd1, rd); checkOutput("disabled_status", rd, 32'h0000_0021);

        // Asynchronous reset during a low data bit of 0x13 (bit 2)
        writeReg(2'd3, 32'd1);
        repeat (13) @(posedge i_Clk);
        #3;
        checkOutput("pre_reset_low", {31'd0, o_Tx}, 32'd0);
        i_Rst_n = 1'b0;
        #1;
        checkOutput("async_rst_tx", {31'd0, o_Tx}, 32'd1);
        checkOutput("async_rst_rdata", o_RData, 32'd0);
        checkOutput("async_rst_irq", {31'd0, o_Irq}, 32'd0);
        @(negedge i_Clk);
        i_Rst_n = 1'b1;
        readReg(2'd1, rd); checkOutput("post_rst_status", rd, 32'h0000_0002);
        readReg(2'd2, rd); checkOutput("post_rst_bauddiv", rd, 32'd867);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/uart_tx_slave.md
# uart_tx_slave

Memory-mapped UART transmitter occupying one 4-register slave port of the SoC peripheral interconnect (word index on address bits [1:0]). The CPU writes bytes into a 4-entry TX FIFO, and an 8N1 shifter serialises them onto `o_Tx` at a programmable bit period. Read data is registered and returned one cycle after the read request, matching the interconnect's registered read-data mux.

## Interface
- `BUS_WIDTH`, 32: data/address width.
- `FIFO_DEPTH`, 4: TX FIFO entries; must be a power of two.
- `RESET_BAUDDIV`, 867: reset value of BAUDDIV (115200 baud at 100 MHz).

- `i_Clk`  in  1  system clock.
- `i_Rst_n`  in  1  asynchronous, active-low reset.
- `i_WEnable`  in  1  write strobe; asserted only when exactly `1'b1`, so Z/X counts as idle.
- `i_WAddr`  in  BUS_WIDTH  write address; only [1:0] decoded.
- `i_WData`  in  BUS_WIDTH  write data.
- `i_REnable`  in  1  read strobe; same rule as `i_WEnable`.
- `i_RAddr`  in  BUS_WIDTH  read address; only [1:0] decoded.
- `o_RData`  out  BUS_WIDTH  registered read data.
- `o_Tx`  out  1  serial line; idles high.
- `o_Irq`  out  1  level interrupt: `CTRL.IRQEN & fifo_empty & ~busy`.

## Operation
- **Register map (word index):**
  - 0 TXDATA: a write pushes `WData[7:0]`. A read returns 0.
  - 1 STATUS (read): bit0 full, bit1 empty, bit2 busy, bits[5:3] count (0..4), bit6 OVF (sticky). Writing 1 to bit6 clears OVF. Other bits read 0.
  - 2 BAUDDIV: bits[15:0] R/W. Bit period = BAUDDIV+1 clocks. Upper bits read 0.
  - 3 CTRL: bit0 TXEN, bit1 IRQEN. R/W, upper bits read 0.
- **Push rule:** a push is accepted if the FIFO is not full, or a pop occurs on the same edge. Otherwise the byte is dropped and OVF is set.
- **FIFO:** circular, with a read pointer, a write pointer and a count. Pointers wrap modulo FIFO_DEPTH.
- **FSM states:** IDLE, START, DATA, STOP.
  - IDLE → START when TXEN=1 and the FIFO is non-empty. On that edge: pop the head into the shift register, latch BAUDDIV into a working divisor, clear the bit counter.
  - START: `o_Tx`=0 for one bit period, then → DATA.
  - DATA: drive `shift[0]`, LSB first. At the end of each bit period, shift right. After 8 bits → STOP.
  - STOP: `o_Tx`=1 for one bit period. At its end:
    - → START with an immediate pop if TXEN=1 and the FIFO is non-empty (back-to-back frames);
    - otherwise → IDLE.
- **Busy:** busy = state ≠ IDLE.
- **Clearing TXEN:** clearing TXEN mid-frame finishes the current frame; no new frame starts.
- **BAUDDIV writes:** writes mid-frame affect only the next frame.
- **Baud counter:** counts 0..divisor. Each bit period is exactly divisor+1 clocks.
- **Reads:** on an edge with `i_REnable`=1, `o_RData` ← register[`i_RAddr[1:0]`] using pre-edge values. Otherwise `o_RData` holds its value.
- **Same-edge write and read of one register:** the read returns the old value.

## Timing
- **Reset values:**
  - `o_Tx`=1, `o_RData`=0, `o_Irq`=0.
  - FIFO empty, state IDLE, BAUDDIV=RESET_BAUDDIV, CTRL=0, OVF=0.
  - Reset takes effect asynchronously, including mid-frame: `o_Tx` returns high immediately.
- **Read latency:** 1 cycle. Data is valid in the cycle after the read request.
- **Write latency:** a write updates state on the request edge; STATUS reflects it on the next read.
- **Frame start:** with TXEN=1, a push into an empty idle FIFO produces the start bit (`o_Tx`=0) 1 cycle after the push edge. The cycle after the push is the IDLE→START evaluation; the start bit begins the cycle after that.
- **Frame length:** 10×(divisor+1) clocks from start-bit begin to stop-bit end. No idle gap between back-to-back frames.
- **`o_Irq` timing:** combinational from registered state. It asserts in the first cycle after STOP→IDLE with an empty FIFO.

## Test plan
- **Reset state:** reset, then read index 1 → `o_RData`=0x0000_0002 (empty) one cycle later. Read index 2 → 867. `o_Tx`=1.
- **Single byte:** write BAUDDIV=3, CTRL=1, TXDATA=0xA5 → `o_Tx` shows 0, then 1,0,1,0,0,1,0,1, then 1, each held 4 clocks (40 clocks total). STATUS busy=1 during the frame, then STATUS=0x02.
- **Overflow:** with TXEN=0, write 5 bytes 0x01..0x05 → STATUS=0x61 (full, count 4, OVF). Write 0x40 to index 1 → OVF clears, STATUS=0x21. Then set TXEN=1 → frames 0x01..0x04 go out back-to-back with no idle gap, and 0x05 never appears.
- **Push with simultaneous pop:** FIFO full while STOP ends with TXEN=1, and a push lands on the pop edge → push accepted, OVF stays 0, count stays 4.
- **Interrupt and disable:** IRQEN=1 and TXEN=1, send 1 byte → `o_Irq`=0 while busy, then 1 after the stop bit. Clearing TXEN mid-frame completes that frame only.
- **Async reset:** assert `i_Rst_n`=0 during the DATA state while `o_Tx`=0 → `o_Tx`=1 and `o_RData`=0 immediately, FIFO empty after release.
